writeback_sequencer: RTL and testbench

Write-back stage between the MEM/WB boundary and the 32×64-bit register file. It has one write port, so it turns each retiring instruction into register-file write strobes: one write for ordinary instructions and two back-to-back writes for load-pair (LDP).
- Applies the XZR rule: writes to register 31 are dropped.
- Back-pressures the MEM stage for one cycle during the second write of a pair.
- Keeps a retired-instruction counter.

---
 rtl/writeback_sequencer.sv | 114 +++++++++++
 tb/tb_writeback_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_sequencer.sv
// writeback_sequencer
// Write-back stage between the MEM/WB boundary and a single-write-port
// register file. Ordinary instructions produce one write strobe; load-pair
// (LDP) produces two back-to-back writes, back-pressuring MEM for one cycle.
// Writes to register 31 (XZR) are suppressed. Keeps a retired-instruction count.
//
// Ports:
//   clock           - single clock, rising-edge
//   reset           - synchronous, active-low
//   In_valid        - MEM stage presents a retiring instruction
//   In_ready        - sequencer accepts this cycle (transfer = In_valid & In_ready)
//   In_RegWrite     - instruction writes a register
//   In_MemtoReg     - 1: write memory data, 0: write ALU result
//   In_Pair         - LDP second destination present (only with In_MemtoReg=1)
//   In_Rd, In_Rd2   - first / second destination index
//   In_ALU_result   - ALU result
//   In_Mem_data     - load data, first word
//   In_Mem_data2    - load data, second word
//   Write_register  - register-file write index
//   Write_data      - register-file write data
//   RegWrite        - register-file write strobe
//   Stall           - ~In_ready, to the hazard unit
//   Retired_count   - instructions accepted since reset (wraps)

module writeback_sequencer #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  In_valid,
    output logic                  In_ready,
    input  logic                  In_RegWrite,
    input  logic                  In_MemtoReg,
    input  logic                  In_Pair,
    input  logic [ADDR_WIDTH-1:0] In_Rd,
    input  logic [ADDR_WIDTH-1:0] In_Rd2,
    input  logic [DATA_WIDTH-1:0] In_ALU_result,
    input  logic [DATA_WIDTH-1:0] In_Mem_data,
    input  logic [DATA_WIDTH-1:0] In_Mem_data2,
    output logic [ADDR_WIDTH-1:0] Write_register,
    output logic [DATA_WIDTH-1:0] Write_data,
    output logic                  RegWrite,
    output logic                  Stall,
    output logic [31:0]           Retired_count
);

    localparam logic [ADDR_WIDTH-1:0] XzrIdx = ADDR_WIDTH'(31);

    typedef enum logic {
        StAccept,
        StSecond
    } state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   wr_reg_q;
    logic [DATA_WIDTH-1:0]   wr_data_q;
    logic                    reg_write_q;
    logic [ADDR_WIDTH-1:0]   hold_rd_q;
    logic [DATA_WIDTH-1:0]   hold_data_q;
    logic [31:0]             retired_q;

    // Pair is only honoured for a register-writing load.
    logic is_pair;
    assign is_pair = In_RegWrite & In_MemtoReg & In_Pair;

    always_ff @(posedge clock) begin
        if (!reset) begin
            // Also aborts a pending second write when taken in StSecond.
            state_q     <= StAccept;
            wr_reg_q    <= '0;
            wr_data_q   <= '0;
            reg_write_q <= 1'b0;
            hold_rd_q   <= '0;
            hold_data_q <= '0;
            retired_q   <= '0;
        end else begin
            unique case (state_q)
                StAccept: begin
                    // In_ready is 1 here, so In_valid alone marks a transfer.
                    if (In_valid) begin
                        wr_reg_q    <= In_Rd;
                        wr_data_q   <= In_MemtoReg ? In_Mem_data : In_ALU_result;
                        reg_write_q <= In_RegWrite & (In_Rd != XzrIdx);
                        retired_q   <= retired_q + 32'd1;
                        if (is_pair) begin
                            hold_rd_q   <= In_Rd2;
                            hold_data_q <= In_Mem_data2;
                            state_q     <= StSecond;
                        end
                    end else begin
                        reg_write_q <= 1'b0;
                    end
                end
                StSecond: begin
                    // Upstream holds its instruction; In_valid is ignored here.
                    wr_reg_q    <= hold_rd_q;
                    wr_data_q   <= hold_data_q;
                    reg_write_q <= (hold_rd_q != XzrIdx);
                    state_q     <= StAccept;
                end
            endcase
        end
    end

    // Ready depends on state only: no combinational path from In_valid.
    assign In_ready       = (state_q == StAccept);
    assign Stall          = ~In_ready;
    assign Write_register = wr_reg_q;
    assign Write_data     = wr_data_q;
    assign RegWrite       = reg_write_q;
    assign Retired_count  = retired_q;

endmodule

// File: tb/tb_writeback_sequencer.sv
// Directed bench for writeback_sequencer with a scoreboard of expected
// per-cycle outputs and a behavioural register file fed by the write port.

module tb_writeback_sequencer;

    localparam int DW = 64;
    localparam int AW = 5;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid, in_rw, in_m2r, in_pair;
    logic [AW-1:0] in_rd, in_rd2;
    logic [DW-1:0] in_alu, in_md, in_md2;
    logic          in_ready, stall, reg_write;
    logic [AW-1:0] write_register;
    logic [DW-1:0] write_data;
    logic [31:0]   retired_count;

    always #5 clock = ~clock;

    writeback_sequencer #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .In_valid      (in_valid),
        .In_ready      (in_ready),
        .In_RegWrite   (in_rw),
        .In_MemtoReg   (in_m2r),
        .In_Pair       (in_pair),
        .In_Rd         (in_rd),
        .In_Rd2        (in_rd2),
        .In_ALU_result (in_alu),
        .In_Mem_data   (in_md),
        .In_Mem_data2  (in_md2),
        .Write_register(write_register),
        .Write_data    (write_data),
        .RegWrite      (reg_write),
        .Stall         (stall),
        .Retired_count (retired_count)
    );

    // Register file consumer: commits on the edge ending a RegWrite cycle.
    logic [DW-1:0] rf [32];
    always @(posedge clock) begin
        if (reg_write) rf[write_register] <= write_data;
    end

    typedef struct packed {
        logic          we;
        logic [AW-1:0] wr;
        logic [DW-1:0] wd;
        logic          rdy;
        logic [31:0]   cnt;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference state of the sequencer as described by its behaviour.
    logic          m_second = 1'b0;
    logic [AW-1:0] m_hrd = '0, m_wr = '0;
    logic [DW-1:0] m_hd = '0, m_wd = '0;
    logic          m_we = 1'b0;
    logic [31:0]   m_cnt = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Compute the outputs expected after the coming edge and queue them.
    task automatic predict();
        exp_t e;
        if (!reset) begin
            m_second = 1'b0; m_we = 1'b0; m_wr = '0; m_wd = '0;
            m_cnt = '0; m_hrd = '0; m_hd = '0;
        end else if (m_second) begin
            m_we = (m_hrd != 5'd31);
            m_wr = m_hrd;
            m_wd = m_hd;
            m_second = 1'b0;
        end else if (in_valid) begin
            m_wr  = in_rd;
            m_wd  = in_m2r ? in_md : in_alu;
            m_we  = in_rw && (in_rd != 5'd31);
            m_cnt = m_cnt + 32'd1;
            if (in_rw && in_m2r && in_pair) begin
                m_hrd = in_rd2;
                m_hd = in_md2;
                m_second = 1'b1;
            end
        end else begin
            m_we = 1'b0;
        end
        e.we = m_we; e.wr = m_wr; e.wd = m_wd; e.rdy = !m_second; e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        chk("RegWrite", 64'(reg_write), 64'(e.we));
        chk("Write_register", 64'(write_register), 64'(e.wr));
        chk("Write_data", write_data, e.wd);
        chk("In_ready", 64'(in_ready), 64'(e.rdy));
        chk("Stall", 64'(stall), 64'(!e.rdy));
        chk("Retired_count", 64'(retired_count), 64'(e.cnt));
    endtask

    // Called at a negedge with inputs already set; returns at the next negedge.
    task automatic tick();
        predict();
        @(posedge clock);
        #1;
        check_out();
        @(negedge clock);
    endtask

    task automatic set_in(input logic v, input logic rw, input logic m2r, input logic pr,
                          input logic [AW-1:0] rd, input logic [AW-1:0] rd2,
                          input logic [DW-1:0] alu, input logic [DW-1:0] md,
                          input logic [DW-1:0] md2);
        in_valid = v; in_rw = rw; in_m2r = m2r; in_pair = pr;
        in_rd = rd; in_rd2 = rd2; in_alu = alu; in_md = md; in_md2 = md2;
    endtask

    task automatic idle();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);
    endtask

    initial begin
        logic [31:0] base;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        reset = 1'b0;
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 5'd0, 64'h55, 64'h66, 64'h77);
        @(negedge clock);

        // Reset held for two edges with In_valid asserted.
        tick();
        tick();
        chk("reset_count", 64'(retired_count), 64'd0);

        // First write after reset.
        reset = 1'b1;
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 5'd0, 64'h1234, 64'hDEAD, 64'h0);
        tick();

        // Back-to-back singles, MemtoReg alternating.
        base = m_cnt;
        for (int i = 1; i <= 4; i++) begin
            if (i % 2 == 0)
                set_in(1'b1, 1'b1, 1'b1, 1'b0, AW'(i), '0, 64'hBAD, 64'(i * 10), '0);
            else
                set_in(1'b1, 1'b1, 1'b0, 1'b0, AW'(i), '0, 64'(i * 10), 64'hBAD, '0);
            tick();
        end
        chk("singles_count", 64'(retired_count - base), 64'd4);

        // XZR: no strobe, still counted.
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 5'd31, '0, 64'hFFFF, '0, '0);
        tick();
        idle();
        tick();

        // Load pair, then a held single during the SECOND cycle.
        base = m_cnt;
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 5'd6, 64'h0, 64'hAAAA, 64'hBBBB);
        tick();
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 5'd8, '0, 64'h88, '0, '0);
        tick();
        tick();
        idle();
        tick();
        chk("pair_count", 64'(retired_count - base), 64'd2);
        chk("rf_r5", rf[5], 64'hAAAA);
        chk("rf_r6", rf[6], 64'hBBBB);
        chk("rf_r8", rf[8], 64'h88);

        // Pair to XZR on the second slot.
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 5'd10, 5'd31, 64'h0, 64'h1010, 64'h3131);
        tick();
        idle();
        tick();
        tick();

        // Pair with identical destinations: second write wins.
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 5'd7, 64'h0, 64'hAAAA, 64'hBBBB);
        tick();
        idle();
        tick();
        tick();
        chk("rf_r7", rf[7], 64'hBBBB);

        // Pair flag without MemtoReg or RegWrite: single instruction.
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 5'd11, 5'd12, 64'h1111, 64'h2222, 64'h3333);
        tick();
        set_in(1'b1, 1'b0, 1'b1, 1'b1, 5'd13, 5'd14, 64'h4444, 64'h5555, 64'h6666);
        tick();
        idle();
        tick();

        // Reset during SECOND aborts the second write.
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 5'd20, 5'd21, 64'h0, 64'h2020, 64'h2121);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        idle();
        tick();
        tick();
        chk("abort_count", 64'(retired_count), 64'd0);
        chk("abort_rf_r21", rf[21], 64'h0);

        // Counter wrap via a forced start value.
        force dut.retired_q = 32'hFFFF_FFFE;
        m_cnt = 32'hFFFF_FFFE;
        tick();
        release dut.retired_q;
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 5'd2, '0, 64'h22, '0, '0);
        tick();
        chk("wrap_ffffffff", 64'(retired_count), 64'hFFFF_FFFF);
        tick();
        chk("wrap_zero", 64'(retired_count), 64'h0);
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
